// File: rtl/sin_lut_arb_pkg.sv
// sin_lut_arb_pkg
// Shared types and helpers for the sin_lut_arb shared-LUT arbiter.
//   phi_width(depth) : phase width for a full-wave table of 'depth' entries
//   tag_t            : tag carried alongside each in-flight LUT read
//   fold_phi(phi, w) : quarter-wave address fold, returns {addr, neg}
// Optional feature macro: SIN_LUT_ARB_QUARTER_WAVE_EN (adds the neg tag bit).
package sin_lut_arb_pkg;

  // Widest channel id (N_CH up to 8) and widest phase the fold helper handles.
  localparam int CH_W_MAX  = 3;
  localparam int PHI_W_MAX = 16;

  typedef logic [PHI_W_MAX-1:0] phi_max_t;

  // Quarter-wave table sampling: entry k holds
  //   round(A * sin(2*pi*(2k+1) / (2*DEPTH)))
  // i.e. each entry sits half a step into its bin, so mirroring the offset
  // (~o) in odd quadrants lands on exactly the symmetric sample.
  localparam int QW_HALF_STEP_NUM = 1;
  localparam int QW_HALF_STEP_DEN = 2;

  function automatic int phi_width(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic                vld;
    logic [CH_W_MAX-1:0] ch_id;
`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
    logic                neg;
`endif
  } tag_t;

  // Result is {addr, neg}; addr occupies the upper PHI_W_MAX bits, of which
  // only the low phi_w-2 are meaningful.
  function automatic logic [PHI_W_MAX:0] fold_phi(input phi_max_t phi,
                                                  input int       phi_w);
    phi_max_t   mask;
    phi_max_t   o;
    logic [1:0] q;
    mask = (phi_max_t'(1) << (phi_w - 2)) - phi_max_t'(1);
    o    = phi & mask;
    q    = 2'(phi >> (phi_w - 2));
    return {(q[0] ? (~o & mask) : o), q[1]};
  endfunction

endpackage

// File: rtl/sin_lut_arb_rr.sv
// rr_arb
// Combinational round-robin grant with a registered rotating pointer.
// Reusable by any controller that time-shares a single resource.
//   clk, rst (sync, active-low)
//   req       : per-requester request
//   grant     : one-hot grant or zero (forced zero while rst=0)
//   grant_id  : index of the granted requester
//   grant_vld : a grant is issued this cycle
module rr_arb #(
  parameter int  N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_id,
  output logic          grant_vld
);

  logic [PW-1:0] rr_ptr;

  // Scan from rr_ptr upward (wrapping) and take the first requester.
  always_comb begin
    logic [PW-1:0] idx;
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(rr_ptr) + i) % N);
      if (rst && !grant_vld && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_vld  = 1'b1;
      end
    end
  end

  // Pointer moves to just past the winner; holds when nobody is granted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (int'(grant_id) == N - 1) ? '0 : PW'(grant_id + 1'b1);
    end
  end

endmodule

// File: rtl/sin_lut_arb.sv
// sin_lut_arb
// Time-shares one sin_lut among N_CH phase channels. Each granted request
// drives the LUT address one cycle later; a tag pipeline follows the read
// and steers the returned sample into that channel's holding register.
//   clk, rst (sync, active-low)
//   req_valid/req_phi/req_ready : per-channel request handshake
//   lut_phi/lut_wav             : shared LUT address out, data in
//   rsp_valid/rsp_wav           : per-channel update pulse and held sample
// Optional feature macro: SIN_LUT_ARB_QUARTER_WAVE_EN (quarter-wave table,
// address fold and result negation).
module sin_lut_arb
  import sin_lut_arb_pkg::*;
#(
  parameter int  N_CH    = 4,
  parameter int  WIDTH   = 24,
  parameter int  DEPTH   = 256,
  parameter int  LUT_LAT = 1,
  localparam int PHI_W   = phi_width(DEPTH),
`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
  localparam int LUT_AW  = PHI_W - 2
`else
  localparam int LUT_AW  = PHI_W
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         req_valid,
  input  logic [N_CH*PHI_W-1:0]   req_phi,
  output logic [N_CH-1:0]         req_ready,
  output logic [LUT_AW-1:0]       lut_phi,
  input  logic [WIDTH-1:0]        lut_wav,
  output logic [N_CH-1:0]         rsp_valid,
  output logic [N_CH*WIDTH-1:0]   rsp_wav
);

  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]   grant;
  logic [CH_W-1:0]   grant_id;
  logic              grant_vld;
  logic [PHI_W-1:0]  phi_sel;
  logic [LUT_AW-1:0] addr_nxt;
  tag_t              tag_nxt;
  tag_t              pipe [LUT_LAT+1];
  tag_t              ret;
  logic [WIDTH-1:0]  ret_wav;

  rr_arb #(.N(N_CH)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .grant    (grant),
    .grant_id (grant_id),
    .grant_vld(grant_vld)
  );

  assign req_ready = grant;

  // Phase of the granted channel (zero when idle; only used on a grant).
  always_comb begin
    phi_sel = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (grant[c]) phi_sel = req_phi[c*PHI_W +: PHI_W];
    end
  end

`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
  logic [PHI_W_MAX:0] fold_vec;
  assign fold_vec = fold_phi(phi_max_t'(phi_sel), PHI_W);
  assign addr_nxt = LUT_AW'(fold_vec >> 1);
`else
  assign addr_nxt = phi_sel;
`endif

  // Tag entering the pipeline; vld=0 on idle cycles keeps slots empty.
  always_comb begin
    tag_nxt       = '0;
    tag_nxt.vld   = grant_vld;
    tag_nxt.ch_id = CH_W_MAX'(grant_id);
`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
    tag_nxt.neg   = fold_vec[0];
`endif
  end

  // Address register holds its last value while idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lut_phi <= '0;
    end else if (grant_vld) begin
      lut_phi <= addr_nxt;
    end
  end

  // Stage k is valid during T+1+k; the last stage lines up with lut_wav.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k <= LUT_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= tag_nxt;
      for (int k = 1; k <= LUT_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign ret = pipe[LUT_LAT];

  always_comb begin
`ifdef SIN_LUT_ARB_QUARTER_WAVE_EN
    ret_wav = ret.neg ? -lut_wav : lut_wav;
`else
    ret_wav = lut_wav;
`endif
  end

  // Retire: update only the tagged channel and pulse its valid for a cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_wav   <= '0;
    end else begin
      rsp_valid <= '0;
      for (int c = 0; c < N_CH; c++) begin
        if (ret.vld && ret.ch_id == CH_W_MAX'(c)) begin
          rsp_valid[c]              <= 1'b1;
          rsp_wav[c*WIDTH +: WIDTH] <= ret_wav;
        end
      end
    end
  end

endmodule
